stack_lifo: RTL and testbench

- Parametrised LIFO stack; next-generation replacement for the processor's fixed 16x16 operand/return stack.
- Registered memory writes (no combinational storage), full/empty/count status, error flags, combinational top-of-stack peek.
- Simultaneous push+pop performs an atomic replace-top.
- Sits between the control unit / datapath and the register file.

---
 rtl/stack_pkg.sv | 19 +
 rtl/stack_mem.sv | 27 ++
 rtl/stack_lifo.sv | 131 +++++++++++++
 tb/tb_stack_lifo.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types and default sizing for the LIFO stack.
package stack_pkg;

  localparam int STACK_DATA_W = 16;
  localparam int STACK_DEPTH  = 16;

  // Encodings match the raw {push,pop} pair so decoding is a plain cast.
  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_PUSH    = 2'b10,
    OP_POP     = 2'b01,
    OP_REPLACE = 2'b11
  } stack_op_t;

  function automatic stack_op_t decode_op(input logic push, input logic pop);
    return stack_op_t'({push, pop});
  endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module stack_mem
  import stack_pkg::*;
#(
  parameter int DATA_W = STACK_DATA_W,
  parameter int DEPTH  = STACK_DEPTH,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Registered write of one entry.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_lifo.sv
// Parametrised LIFO stack with replace-top, status and error pulses.
// Optional high-water mark output enabled by defining STACK_HWM_EN.
module stack_lifo
  import stack_pkg::*;
#(
  parameter int  DATA_W = STACK_DATA_W,
  parameter int  DEPTH  = STACK_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
`ifdef STACK_HWM_EN
  ,
  input  logic              hwm_clr,
  output logic [CNT_W-1:0]  hwm
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  stack_op_t         op;
  logic [CNT_W-1:0]  count_nxt;
  logic [DATA_W-1:0] dout_nxt;
  logic              dout_valid_nxt;
  logic              overflow_nxt;
  logic              underflow_nxt;
  logic              mem_we;
  logic [AW-1:0]     mem_waddr;
  logic [AW-1:0]     top_addr;
  logic [DATA_W-1:0] mem_rdata;

  assign op       = decode_op(push, pop);
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  // Index of the current top; parked at 0 when empty so the read stays in range.
  assign top_addr = empty ? '0 : AW'(count - CNT_W'(1));
  assign top      = empty ? '0 : mem_rdata;

  stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we && !rst),
    .waddr (mem_waddr),
    .wdata (din),
    .raddr (top_addr),
    .rdata (mem_rdata)
  );

  // Decode the operation against the pre-edge count.
  always_comb begin
    count_nxt      = count;
    dout_nxt       = dout;
    dout_valid_nxt = 1'b0;
    overflow_nxt   = 1'b0;
    underflow_nxt  = 1'b0;
    mem_we         = 1'b0;
    mem_waddr      = AW'(count);
    case (op)
      OP_PUSH: begin
        if (!full) begin
          mem_we    = 1'b1;
          count_nxt = count + CNT_W'(1);
        end else begin
          overflow_nxt = 1'b1;
        end
      end
      OP_POP: begin
        if (!empty) begin
          dout_nxt       = mem_rdata;
          dout_valid_nxt = 1'b1;
          count_nxt      = count - CNT_W'(1);
        end else begin
          underflow_nxt = 1'b1;
        end
      end
      OP_REPLACE: begin
        dout_valid_nxt = 1'b1;
        if (!empty) begin
          dout_nxt  = mem_rdata;
          mem_we    = 1'b1;
          mem_waddr = top_addr;
        end else begin
          // Empty replace: the pushed word goes straight out.
          dout_nxt = din;
        end
      end
      default: ;
    endcase
  end

  // Count, output data and single-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      count      <= count_nxt;
      dout       <= dout_nxt;
      dout_valid <= dout_valid_nxt;
      overflow   <= overflow_nxt;
      underflow  <= underflow_nxt;
    end
  end

`ifdef STACK_HWM_EN
  // High-water mark: follows count upward, clear re-bases it to the current count.
  always_ff @(posedge clk) begin
    if (rst)                hwm <= '0;
    else if (hwm_clr)       hwm <= count;
    else if (count > hwm)   hwm <= count;
  end
`endif

endmodule

// File: tb/tb_stack_lifo.sv
// Directed self-checking bench for stack_lifo (DATA_W=16, DEPTH=16).
module tb_stack_lifo;

  localparam int DW = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [DW-1:0] top;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          underflow;
`ifdef STACK_HWM_EN
  logic          hwm_clr = 1'b0;
  logic [CW-1:0] hwm;
`endif

  int tests = 0;
  int failed = 0;

  stack_lifo dut (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .din        (din),
    .dout       (dout),
    .dout_valid (dout_valid),
    .top        (top),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .underflow  (underflow)
`ifdef STACK_HWM_EN
    ,
    .hwm_clr    (hwm_clr),
    .hwm        (hwm)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs on the falling edge; return 1ns after the rising edge.
  task automatic step(input logic r, input logic ps, input logic pp, input logic [DW-1:0] d);
    @(negedge clk);
    rst  = r;
    push = ps;
    pop  = pp;
    din  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    step(1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    // Reset
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    nop();
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_full", 32'(full), 0);
    check("rst_dout", 32'(dout), 0);
    check("rst_dv", 32'(dout_valid), 0);
    check("rst_top", 32'(top), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_unf", 32'(underflow), 0);
`ifdef STACK_HWM_EN
    check("rst_hwm", 32'(hwm), 0);
`endif

    // 1: three pushes
    step(1'b0, 1'b1, 1'b0, 16'h1111);
    check("t1_top_first", 32'(top), 32'h1111);
    step(1'b0, 1'b1, 1'b0, 16'h2222);
    step(1'b0, 1'b1, 1'b0, 16'h3333);
    check("t1_count", 32'(count), 3);
    check("t1_top", 32'(top), 32'h3333);
    check("t1_empty", 32'(empty), 0);
    check("t1_full", 32'(full), 0);

    // 2: pop back in reverse order, then underflow
    step(1'b0, 1'b0, 1'b1, '0);
    check("t2_dout0", 32'(dout), 32'h3333);
    check("t2_dv0", 32'(dout_valid), 1);
    check("t2_top0", 32'(top), 32'h2222);
    step(1'b0, 1'b0, 1'b1, '0);
    check("t2_dout1", 32'(dout), 32'h2222);
    check("t2_dv1", 32'(dout_valid), 1);
    step(1'b0, 1'b0, 1'b1, '0);
    check("t2_dout2", 32'(dout), 32'h1111);
    check("t2_dv2", 32'(dout_valid), 1);
    check("t2_count", 32'(count), 0);
    check("t2_empty", 32'(empty), 1);
    check("t2_top", 32'(top), 0);
    step(1'b0, 1'b0, 1'b1, '0);
    check("t2_unf", 32'(underflow), 1);
    check("t2_unf_dout", 32'(dout), 32'h1111);
    check("t2_unf_dv", 32'(dout_valid), 0);
    check("t2_unf_count", 32'(count), 0);
    nop();
    check("t2_unf_pulse", 32'(underflow), 0);

    // 3: fill, overflow, replace when full
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 16'(i));
    check("t3_full", 32'(full), 1);
    check("t3_count", 32'(count), 16);
    check("t3_top", 32'(top), 32'h000F);
    step(1'b0, 1'b1, 1'b0, 16'hBEEF);
    check("t3_ovf", 32'(overflow), 1);
    check("t3_ovf_count", 32'(count), 16);
    check("t3_ovf_top", 32'(top), 32'h000F);
    check("t3_ovf_dv", 32'(dout_valid), 0);
    nop();
    check("t3_ovf_pulse", 32'(overflow), 0);
    step(1'b0, 1'b1, 1'b1, 16'hAAAA);
    check("t3_rep_dout", 32'(dout), 32'h000F);
    check("t3_rep_dv", 32'(dout_valid), 1);
    check("t3_rep_top", 32'(top), 32'hAAAA);
    check("t3_rep_count", 32'(count), 16);
    check("t3_rep_ovf", 32'(overflow), 0);
    step(1'b0, 1'b0, 1'b1, '0);
    check("t3_pop_dout", 32'(dout), 32'hAAAA);
    check("t3_pop_count", 32'(count), 15);
    check("t3_pop_top", 32'(top), 32'h000E);

    // 4: replace on empty bypasses din to dout
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 16'h5A5A);
    check("t4_dout", 32'(dout), 32'h5A5A);
    check("t4_dv", 32'(dout_valid), 1);
    check("t4_count", 32'(count), 0);
    check("t4_ovf", 32'(overflow), 0);
    check("t4_unf", 32'(underflow), 0);
    check("t4_top", 32'(top), 0);

    // 5: reset wins over a simultaneous push
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 16'h0100 + 16'(i));
    check("t5_count5", 32'(count), 5);
    check("t5_top5", 32'(top), 32'h0104);
    step(1'b1, 1'b1, 1'b0, 16'hCAFE);
    check("t5_count", 32'(count), 0);
    check("t5_dout", 32'(dout), 0);
    check("t5_dv", 32'(dout_valid), 0);
    check("t5_ovf", 32'(overflow), 0);
    check("t5_unf", 32'(underflow), 0);
    check("t5_empty", 32'(empty), 1);
`ifdef STACK_HWM_EN
    check("t5_hwm_rst", 32'(hwm), 0);
`endif
    step(1'b0, 1'b0, 1'b1, '0);
    check("t5_unf", 32'(underflow), 1);
    check("t5_unf_count", 32'(count), 0);

`ifdef STACK_HWM_EN
    // 6: high-water mark
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 16'h0200 + 16'(i));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, '0);
    nop();
    check("t6_hwm7", 32'(hwm), 7);
    check("t6_count3", 32'(count), 3);
    @(negedge clk);
    hwm_clr = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    hwm_clr = 1'b0;
    check("t6_hwm_clr", 32'(hwm), 3);
    step(1'b0, 1'b1, 1'b0, 16'h0300);
    nop();
    check("t6_hwm4", 32'(hwm), 4);
    check("t6_count4", 32'(count), 4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
